// File: rtl/ddr_rd_arbiter_if.sv
// Bundled channel-side and memory-side signals of the DDR read arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding fabric's view.
interface ddr_rd_arbiter_if #(
    parameter int DDR_W      = 512,
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 8
);
    logic [1:0][DDR_ADDR_W-1:0] ch_addr;
    logic [1:0][BURST_W-1:0]    ch_size;
    logic [1:0]                 ch_addr_valid;
    logic [1:0]                 ch_addr_ready;
    logic [DDR_W-1:0]           ch_data;
    logic [1:0]                 ch_data_valid;
    logic [1:0]                 ch_data_ready;
    logic [DDR_ADDR_W-1:0]      mem_addr;
    logic [BURST_W-1:0]         mem_size;
    logic                       mem_addr_valid;
    logic                       mem_addr_ready;
    logic [DDR_W-1:0]           mem_data;
    logic                       mem_data_valid;
    logic                       mem_data_ready;
    logic                       idle;

    modport master (
        input  ch_addr, ch_size, ch_addr_valid, ch_data_ready,
        input  mem_addr_ready, mem_data, mem_data_valid,
        output ch_addr_ready, ch_data, ch_data_valid,
        output mem_addr, mem_size, mem_addr_valid, mem_data_ready, idle
    );

    modport slave (
        output ch_addr, ch_size, ch_addr_valid, ch_data_ready,
        output mem_addr_ready, mem_data, mem_data_valid,
        input  ch_addr_ready, ch_data, ch_data_valid,
        input  mem_addr, mem_size, mem_addr_valid, mem_data_ready, idle
    );
endinterface

// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter sharing one in-order DDR read port between two channels;
// an in-order tag FIFO of {channel, size} steers returning beats to their owner.
module ddr_rd_arbiter #(
    parameter int DDR_W       = 512,
    parameter int DDR_ADDR_W  = 32,
    parameter int BURST_W     = 8,
    parameter int OUTSTANDING = 4
) (
    input logic clk,
    input logic rst,
    ddr_rd_arbiter_if.master bus
);
    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);

    logic [DDR_ADDR_W-1:0] addr_q;
    logic [BURST_W-1:0]    size_q;
    logic                  addr_vld_q;
    logic                  rr_ptr;

    logic                  tag_ch   [OUTSTANDING];
    logic [BURST_W-1:0]    tag_size [OUTSTANDING];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      tag_count;
    logic [BURST_W-1:0]    beat_cnt;

    logic                  empty;
    logic                  grant;
    logic                  load;
    logic                  head_ch;
    logic [BURST_W-1:0]    head_size;
    logic                  beat_hs;
    logic                  pop;

    // Address side: grant selection and load qualification
    always_comb begin
        grant = rr_ptr;
        if (bus.ch_addr_valid == 2'b01) begin
            grant = 1'b0;
        end else if (bus.ch_addr_valid == 2'b10) begin
            grant = 1'b1;
        end
    end

    assign empty = (tag_count == '0);
    // Registered count only: a same-cycle pop does not free a slot for this load.
    assign load  = (!addr_vld_q || bus.mem_addr_ready) && (tag_count < FULL_CNT)
                   && (|bus.ch_addr_valid);

    assign bus.ch_addr_ready  = load ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_size       = size_q;
    assign bus.mem_addr_valid = addr_vld_q;

    // Data side: head tag steers the shared beat bus
    assign head_ch   = tag_ch[rd_ptr];
    assign head_size = tag_size[rd_ptr];

    assign bus.ch_data        = bus.mem_data;
    assign bus.ch_data_valid  = (bus.mem_data_valid && !empty) ? (head_ch ? 2'b10 : 2'b01) : 2'b00;
    assign bus.mem_data_ready = !empty && bus.ch_data_ready[head_ch];
    assign beat_hs            = bus.mem_data_valid && bus.mem_data_ready;
    assign pop                = beat_hs && (beat_cnt == head_size);

    assign bus.idle = empty && !addr_vld_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            size_q     <= '0;
            addr_vld_q <= 1'b0;
            rr_ptr     <= 1'b0;
        end else if (load) begin
            addr_q     <= bus.ch_addr[grant];
            size_q     <= bus.ch_size[grant];
            addr_vld_q <= 1'b1;
            rr_ptr     <= ~grant;
        end else if (bus.mem_addr_ready) begin
            addr_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            tag_ch[wr_ptr]   <= grant;
            tag_size[wr_ptr] <= bus.ch_size[grant];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tag_count <= '0;
            beat_cnt  <= '0;
        end else begin
            if (load) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({load, pop})
                2'b10:   tag_count <= tag_count + CNT_W'(1);
                2'b01:   tag_count <= tag_count - CNT_W'(1);
                default: tag_count <= tag_count;
            endcase
            if (beat_hs) begin
                beat_cnt <= pop ? '0 : beat_cnt + BURST_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed testbench for ddr_rd_arbiter with hand-computed expectations.
module tb_ddr_rd_arbiter;
    localparam int DDR_W       = 512;
    localparam int DDR_ADDR_W  = 32;
    localparam int BURST_W     = 8;
    localparam int OUTSTANDING = 4;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    ddr_rd_arbiter_if #(.DDR_W(DDR_W), .DDR_ADDR_W(DDR_ADDR_W), .BURST_W(BURST_W)) bus ();

    ddr_rd_arbiter #(
        .DDR_W(DDR_W), .DDR_ADDR_W(DDR_ADDR_W), .BURST_W(BURST_W), .OUTSTANDING(OUTSTANDING)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.ch_addr        = '0;
        bus.ch_size        = '0;
        bus.ch_addr_valid  = 2'b00;
        bus.ch_data_ready  = 2'b00;
        bus.mem_addr_ready = 1'b1;
        bus.mem_data       = '0;
        bus.mem_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        total_cnt++; if (bus.mem_addr_valid !== 1'b0) $display("FAIL reset_addr_valid: got %0b want 0", bus.mem_addr_valid); else pass_cnt++;
        total_cnt++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); else pass_cnt++;
        total_cnt++; if (bus.mem_size !== 8'h0) $display("FAIL reset_mem_size: got %h want 0", bus.mem_size); else pass_cnt++;
        total_cnt++; if (bus.idle !== 1'b1) $display("FAIL reset_idle: got %0b want 1", bus.idle); else pass_cnt++;
        total_cnt++; if (bus.mem_data_ready !== 1'b0) $display("FAIL reset_mem_data_ready: got %0b want 0", bus.mem_data_ready); else pass_cnt++;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_burst();
        logic [DDR_W-1:0] beat;
        bus.ch_addr[0]       = 32'h100;
        bus.ch_size[0]       = 8'd3;
        bus.ch_addr_valid    = 2'b01;
        #1;
        total_cnt++; if (bus.ch_addr_ready !== 2'b01) $display("FAIL single_addr_ready: got %b want 01", bus.ch_addr_ready); else pass_cnt++;
        tick();
        bus.ch_addr_valid = 2'b00;
        total_cnt++; if (bus.mem_addr_valid !== 1'b1) $display("FAIL single_addr_valid: got %0b want 1", bus.mem_addr_valid); else pass_cnt++;
        total_cnt++; if (bus.mem_addr !== 32'h100) $display("FAIL single_mem_addr: got %h want 100", bus.mem_addr); else pass_cnt++;
        total_cnt++; if (bus.mem_size !== 8'd3) $display("FAIL single_mem_size: got %0d want 3", bus.mem_size); else pass_cnt++;
        total_cnt++; if (bus.idle !== 1'b0) $display("FAIL single_busy: got %0b want 0", bus.idle); else pass_cnt++;
        bus.ch_data_ready  = 2'b11;
        bus.mem_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat = {(DDR_W/32){32'hA5A50000 | 32'(i)}};
            bus.mem_data = beat;
            #1;
            total_cnt++; if (bus.ch_data_valid !== 2'b01) $display("FAIL single_beat%0d_valid: got %b want 01", i, bus.ch_data_valid); else pass_cnt++;
            total_cnt++; if (bus.ch_data !== beat) $display("FAIL single_beat%0d_data: got %h want %h", i, bus.ch_data[31:0], beat[31:0]); else pass_cnt++;
            total_cnt++; if (bus.mem_data_ready !== 1'b1) $display("FAIL single_beat%0d_ready: got %0b want 1", i, bus.mem_data_ready); else pass_cnt++;
            tick();
        end
        bus.mem_data_valid = 1'b0;
        #1;
        total_cnt++; if (bus.idle !== 1'b1) $display("FAIL single_idle_after: got %0b want 1", bus.idle); else pass_cnt++;
    endtask

    task automatic test_round_robin_outstanding();
        logic [1:0]  exp_rdy;
        logic [31:0] exp_addr;
        do_reset();
        quiet_inputs();
        bus.ch_addr[0]    = 32'h200;
        bus.ch_addr[1]    = 32'h300;
        bus.ch_addr_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_rdy  = (i % 2 == 1) ? 2'b10 : 2'b01;
            exp_addr = (i % 2 == 1) ? 32'h300 : 32'h200;
            #1;
            total_cnt++; if (bus.ch_addr_ready !== exp_rdy) $display("FAIL rr_grant%0d: got %b want %b", i, bus.ch_addr_ready, exp_rdy); else pass_cnt++;
            tick();
            total_cnt++; if (bus.mem_addr !== exp_addr) $display("FAIL rr_mem_addr%0d: got %h want %h", i, bus.mem_addr, exp_addr); else pass_cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++; if (bus.ch_addr_ready !== 2'b00) $display("FAIL full_blocked%0d: got %b want 00", i, bus.ch_addr_ready); else pass_cnt++;
            tick();
        end
        bus.ch_data_ready  = 2'b11;
        bus.mem_data_valid = 1'b1;
        #1;
        total_cnt++; if (bus.ch_data_valid !== 2'b01) $display("FAIL full_first_beat: got %b want 01", bus.ch_data_valid); else pass_cnt++;
        total_cnt++; if (bus.ch_addr_ready !== 2'b00) $display("FAIL full_same_cycle_pop: got %b want 00", bus.ch_addr_ready); else pass_cnt++;
        tick();
        bus.mem_data_valid = 1'b0;
        #1;
        total_cnt++; if (bus.ch_addr_ready !== 2'b01) $display("FAIL full_reenable: got %b want 01", bus.ch_addr_ready); else pass_cnt++;
        tick();
        bus.ch_addr_valid  = 2'b00;
        bus.mem_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
            #1;
            total_cnt++; if (bus.ch_data_valid !== exp_rdy) $display("FAIL rr_drain%0d: got %b want %b", i, bus.ch_data_valid, exp_rdy); else pass_cnt++;
            tick();
        end
        bus.mem_data_valid = 1'b0;
        #1;
        total_cnt++; if (bus.idle !== 1'b1) $display("FAIL rr_idle_after: got %0b want 1", bus.idle); else pass_cnt++;
    endtask

    task automatic test_addr_stall();
        logic [1:0] exp_v;
        bus.mem_addr_ready = 1'b0;
        bus.ch_addr[0]     = 32'h400;
        bus.ch_size[0]     = 8'd2;
        bus.ch_addr_valid  = 2'b01;
        #1;
        total_cnt++; if (bus.ch_addr_ready !== 2'b01) $display("FAIL stall_first_load: got %b want 01", bus.ch_addr_ready); else pass_cnt++;
        tick();
        bus.ch_addr[1]    = 32'h500;
        bus.ch_size[1]    = 8'd5;
        bus.ch_addr_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            total_cnt++; if (bus.ch_addr_ready !== 2'b00) $display("FAIL stall_ready%0d: got %b want 00", i, bus.ch_addr_ready); else pass_cnt++;
            total_cnt++; if (bus.mem_addr !== 32'h400 || bus.mem_size !== 8'd2 || bus.mem_addr_valid !== 1'b1)
                $display("FAIL stall_hold%0d: got addr %h size %0d vld %0b want 400 2 1", i, bus.mem_addr, bus.mem_size, bus.mem_addr_valid);
            else pass_cnt++;
            tick();
        end
        bus.mem_addr_ready = 1'b1;
        #1;
        total_cnt++; if (bus.ch_addr_ready !== 2'b10) $display("FAIL stall_release: got %b want 10", bus.ch_addr_ready); else pass_cnt++;
        tick();
        bus.ch_addr_valid = 2'b00;
        total_cnt++; if (bus.mem_addr !== 32'h500 || bus.mem_size !== 8'd5)
            $display("FAIL stall_next_addr: got %h/%0d want 500/5", bus.mem_addr, bus.mem_size);
        else pass_cnt++;
        bus.ch_data_ready  = 2'b11;
        bus.mem_data_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_v = (i < 3) ? 2'b01 : 2'b10;
            #1;
            total_cnt++; if (bus.ch_data_valid !== exp_v) $display("FAIL stall_drain%0d: got %b want %b", i, bus.ch_data_valid, exp_v); else pass_cnt++;
            tick();
        end
        bus.mem_data_valid = 1'b0;
        #1;
        total_cnt++; if (bus.idle !== 1'b1) $display("FAIL stall_idle_after: got %0b want 1", bus.idle); else pass_cnt++;
    endtask

    task automatic test_back_to_back_backpressure();
        logic [1:0] exp_v;
        bus.ch_addr[1]    = 32'h600;
        bus.ch_size[1]    = 8'd1;
        bus.ch_addr_valid = 2'b10;
        tick();
        total_cnt++; if (bus.mem_addr !== 32'h600) $display("FAIL b2b_addr0: got %h want 600", bus.mem_addr); else pass_cnt++;
        bus.ch_addr[0]    = 32'h700;
        bus.ch_size[0]    = 8'd0;
        bus.ch_addr_valid = 2'b01;
        tick();
        bus.ch_addr_valid = 2'b00;
        total_cnt++; if (bus.mem_addr !== 32'h700 || bus.mem_addr_valid !== 1'b1)
            $display("FAIL b2b_addr1: got %h vld %0b want 700 1", bus.mem_addr, bus.mem_addr_valid);
        else pass_cnt++;
        bus.mem_data_valid = 1'b1;
        bus.ch_data_ready  = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++; if (bus.mem_data_ready !== 1'b0) $display("FAIL bp_mem_ready%0d: got %0b want 0", i, bus.mem_data_ready); else pass_cnt++;
            total_cnt++; if (bus.ch_data_valid !== 2'b10) $display("FAIL bp_valid%0d: got %b want 10", i, bus.ch_data_valid); else pass_cnt++;
            tick();
        end
        bus.ch_data_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            exp_v = (i < 2) ? 2'b10 : 2'b01;
            #1;
            total_cnt++; if (bus.ch_data_valid !== exp_v || bus.mem_data_ready !== 1'b1)
                $display("FAIL bp_release%0d: got %b rdy %0b want %b 1", i, bus.ch_data_valid, bus.mem_data_ready, exp_v);
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++; if (bus.mem_data_ready !== 1'b0 || bus.ch_data_valid !== 2'b00)
            $display("FAIL empty_untagged_beat: got rdy %0b valid %b want 0 00", bus.mem_data_ready, bus.ch_data_valid);
        else pass_cnt++;
        bus.mem_data_valid = 1'b0;
        #1;
        total_cnt++; if (bus.idle !== 1'b1) $display("FAIL bp_idle_after: got %0b want 1", bus.idle); else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        bus.ch_addr[0]    = 32'h800;
        bus.ch_size[0]    = 8'd3;
        bus.ch_addr_valid = 2'b01;
        tick();
        bus.ch_addr_valid  = 2'b00;
        bus.ch_data_ready  = 2'b11;
        bus.mem_data_valid = 1'b1;
        tick();
        #1;
        total_cnt++; if (bus.ch_data_valid !== 2'b01) $display("FAIL midrst_beat2: got %b want 01", bus.ch_data_valid); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (bus.mem_addr_valid !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_size !== 8'h0)
            $display("FAIL midrst_addr_regs: got vld %0b addr %h size %0d want 0 0 0", bus.mem_addr_valid, bus.mem_addr, bus.mem_size);
        else pass_cnt++;
        total_cnt++; if (bus.idle !== 1'b1) $display("FAIL midrst_idle: got %0b want 1", bus.idle); else pass_cnt++;
        total_cnt++; if (bus.ch_data_valid !== 2'b00 || bus.mem_data_ready !== 1'b0)
            $display("FAIL midrst_data: got valid %b rdy %0b want 00 0", bus.ch_data_valid, bus.mem_data_ready);
        else pass_cnt++;
        bus.mem_data_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        total_cnt++; if (bus.idle !== 1'b1) $display("FAIL midrst_idle_release: got %0b want 1", bus.idle); else pass_cnt++;
        bus.ch_addr[0]    = 32'h900;
        bus.ch_size[0]    = 8'd0;
        bus.ch_addr_valid = 2'b01;
        tick();
        bus.ch_addr_valid  = 2'b00;
        bus.mem_data_valid = 1'b1;
        #1;
        total_cnt++; if (bus.ch_data_valid !== 2'b01) $display("FAIL midrst_fresh_beat: got %b want 01", bus.ch_data_valid); else pass_cnt++;
        tick();
        bus.mem_data_valid = 1'b0;
        #1;
        total_cnt++; if (bus.idle !== 1'b1) $display("FAIL midrst_counter_cleared: got %0b want 1", bus.idle); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_single_burst();
        test_round_robin_outstanding();
        test_addr_stall();
        test_back_to_back_backpressure();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
